// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad row scanner with press/release debounce sequencing; one key_valid pulse per confirmed press.
// key_valid/key_code register on the edge after debounce_done is seen; no backpressure, pins are free-running.
module keypad_scan_ctrl #(
    parameter int SCAN_DIV = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cols,
    input  logic       debounce_done,
    output logic [3:0] rows,
    output logic       debouncer_counter_en,
    output logic       key_valid,
    output logic [3:0] key_code
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic [1:0] {
        SCAN       = 2'd0,
        DEBOUNCE   = 2'd1,
        HOLD       = 2'd2,
        RELEASE_DB = 2'd3
    } state_t;

    state_t          state, state_nxt;
    logic [1:0]      row_idx, row_nxt;
    logic [1:0]      col_idx, col_nxt;
    logic [DW-1:0]   dwell, dwell_nxt;
    logic            key_valid_nxt;
    logic [3:0]      key_code_nxt;
    logic            col_single;
    logic [1:0]      col_sel;
    logic            latched_high;
    logic            dwell_last;

    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] k;
        case ({r, c})
            4'h0: k = 4'h1;  4'h1: k = 4'h2;  4'h2: k = 4'h3;  4'h3: k = 4'hA;
            4'h4: k = 4'h4;  4'h5: k = 4'h5;  4'h6: k = 4'h6;  4'h7: k = 4'hB;
            4'h8: k = 4'h7;  4'h9: k = 4'h8;  4'hA: k = 4'h9;  4'hB: k = 4'hC;
            4'hC: k = 4'hE;  4'hD: k = 4'h0;  4'hE: k = 4'hF;  default: k = 4'hD;
        endcase
        return k;
    endfunction

    // Only a single low column is a valid press; zero or several lows (ghosting) keep scanning.
    always_comb begin
        col_single = 1'b0;
        col_sel    = 2'd0;
        case (cols)
            4'b1110: begin col_single = 1'b1; col_sel = 2'd0; end
            4'b1101: begin col_single = 1'b1; col_sel = 2'd1; end
            4'b1011: begin col_single = 1'b1; col_sel = 2'd2; end
            4'b0111: begin col_single = 1'b1; col_sel = 2'd3; end
            default: ;
        endcase
    end

    assign latched_high = cols[col_idx];
    assign dwell_last   = (dwell == DW'(SCAN_DIV - 1));

    always_comb begin
        state_nxt     = state;
        row_nxt       = row_idx;
        col_nxt       = col_idx;
        dwell_nxt     = dwell;
        key_valid_nxt = 1'b0;
        key_code_nxt  = key_code;
        case (state)
            SCAN: begin
                if (!dwell_last) begin
                    dwell_nxt = dwell + 1'b1;
                end else if (col_single) begin
                    col_nxt   = col_sel;
                    state_nxt = DEBOUNCE;
                end else begin
                    row_nxt   = row_idx + 2'd1;
                    dwell_nxt = '0;
                end
            end
            DEBOUNCE: begin
                // A release on the same edge as debounce_done aborts the press.
                if (latched_high) begin
                    state_nxt = SCAN;
                    row_nxt   = row_idx + 2'd1;
                    dwell_nxt = '0;
                end else if (debounce_done) begin
                    state_nxt     = HOLD;
                    key_valid_nxt = 1'b1;
                    key_code_nxt  = key_map(row_idx, col_idx);
                end
            end
            HOLD: begin
                if (latched_high) state_nxt = RELEASE_DB;
            end
            RELEASE_DB: begin
                if (!latched_high) begin
                    state_nxt = HOLD;
                end else if (debounce_done) begin
                    state_nxt = SCAN;
                    row_nxt   = row_idx + 2'd1;
                    dwell_nxt = '0;
                end
            end
            default: state_nxt = SCAN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= SCAN;
            row_idx   <= 2'd0;
            col_idx   <= 2'd0;
            dwell     <= '0;
            key_valid <= 1'b0;
            key_code  <= 4'h0;
        end else begin
            state     <= state_nxt;
            row_idx   <= row_nxt;
            col_idx   <= col_nxt;
            dwell     <= dwell_nxt;
            key_valid <= key_valid_nxt;
            key_code  <= key_code_nxt;
        end
    end

    assign rows                 = ~(4'b0001 << row_idx);
    assign debouncer_counter_en = (state == DEBOUNCE) || (state == RELEASE_DB);

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl at SCAN_DIV=4: vector table, directed press/release sequences,
// and randomized key activity against a tick/mode reference model with a stub debouncer.
module tb_keypad_scan_ctrl;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] cols = 4'hF;
    logic       tb_done = 1'b0;
    logic       use_stub = 1'b0;
    logic       debounce_done;
    logic [3:0] rows;
    logic       en;
    logic       kv;
    logic [3:0] kc;

    int checks = 0;
    int errors = 0;
    int kv_count = 0;
    bit en_seen = 1'b0;
    int stub_cnt = 0;

    keypad_scan_ctrl #(.SCAN_DIV(D)) dut (
        .clk                  (clk),
        .reset                (reset),
        .cols                 (cols),
        .debounce_done        (debounce_done),
        .rows                 (rows),
        .debouncer_counter_en (en),
        .key_valid            (kv),
        .key_code             (kc)
    );

    always #5 clk = ~clk;

    // Stub debouncer: done after 3 consecutive enabled cycles, cleared whenever enable drops.
    always @(posedge clk) begin
        if (!en) stub_cnt <= 0;
        else if (stub_cnt < 3) stub_cnt <= stub_cnt + 1;
    end
    assign debounce_done = use_stub ? (en && stub_cnt == 3) : tb_done;

    task automatic step();
        @(posedge clk);
        #1;
        if (kv === 1'b1) kv_count++;
        if (en === 1'b1) en_seen = 1'b1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [63:0] kmap = 64'h123A456B789CE0FD;
    int          m_mode, m_tick, m_row, m_col;
    logic        m_kv;
    logic [3:0]  m_kc;

    task automatic model_tick();
        int lows, idx;
        m_kv = 1'b0;
        if (!reset) begin
            m_mode = 0; m_tick = 0; m_row = 0; m_col = 0; m_kc = 4'h0;
        end else begin
            case (m_mode)
                0: begin
                    if (m_tick % D == D - 1) begin
                        lows = 0; idx = 0;
                        for (int c = 0; c < 4; c++) if (!cols[c]) begin lows++; idx = c; end
                        if (lows == 1) begin
                            m_row = m_tick / D; m_col = idx; m_mode = 1;
                        end else begin
                            m_tick = (m_tick + 1) % (4 * D);
                        end
                    end else begin
                        m_tick = m_tick + 1;
                    end
                end
                1: begin
                    if (cols[m_col]) begin
                        m_mode = 0; m_tick = ((m_row + 1) % 4) * D;
                    end else if (debounce_done) begin
                        m_kv = 1'b1; m_kc = kmap[63 - 4 * (m_row * 4 + m_col) -: 4]; m_mode = 2;
                    end
                end
                2: if (cols[m_col]) m_mode = 3;
                default: begin
                    if (!cols[m_col]) m_mode = 2;
                    else if (debounce_done) begin
                        m_mode = 0; m_tick = ((m_row + 1) % 4) * D;
                    end
                end
            endcase
        end
    endtask

    function automatic logic [10:0] model_out();
        logic [3:0] r;
        int ri;
        ri = (m_mode == 0) ? m_tick / D : m_row;
        r = ~(4'b0001 << ri);
        return {r, (m_mode == 1 || m_mode == 3), m_kv, m_kc};
    endfunction

    // ---------------- vector table ----------------
    typedef struct {
        logic       rst;
        logic [3:0] cols;
        logic       done;
        logic [3:0] rows;
        logic       en;
        logic       kv;
        logic [3:0] kc;
    } vec_t;

    vec_t tbl[64];
    int   ntbl = 0;

    task automatic add(input logic r, input logic [3:0] c, input logic d,
                       input logic [3:0] er, input logic ee, input logic ek, input logic [3:0] ec);
        tbl[ntbl] = '{r, c, d, er, ee, ek, ec};
        ntbl++;
    endtask

    task automatic wait_rows(input logic [3:0] tgt, input string name);
        int n = 0;
        while (rows !== tgt && n < 40) begin step(); n++; end
        check(name, rows, tgt);
    endtask

    task automatic wait_kv(input string name);
        int n = 0;
        while (kv !== 1'b1 && n < 60) begin step(); n++; end
        check(name, kv, 1'b1);
    endtask

    task automatic do_reset();
        reset = 1'b0; cols = 4'hF;
        step(); step();
        reset = 1'b1;
        kv_count = 0; en_seen = 1'b0;
    endtask

    initial begin
        logic [3:0] rexp;
        int hold, sel;
        logic [10:0] exp_o;

        // Reset, 20 idle scan cycles, key 5 with explicit done, then a release racing done.
        add(1'b0, 4'hF, 1'b0, 4'hE, 1'b0, 1'b0, 4'h0);
        add(1'b0, 4'hF, 1'b0, 4'hE, 1'b0, 1'b0, 4'h0);
        for (int i = 0; i < 20; i++) begin
            rexp = ~(4'b0001 << (((i + 1) / D) % 4));
            add(1'b1, 4'hF, 1'b0, rexp, 1'b0, 1'b0, 4'h0);
        end
        repeat (3) add(1'b1, 4'hD, 1'b0, 4'hD, 1'b0, 1'b0, 4'h0);
        repeat (3) add(1'b1, 4'hD, 1'b0, 4'hD, 1'b1, 1'b0, 4'h0);
        add(1'b1, 4'hD, 1'b1, 4'hD, 1'b0, 1'b1, 4'h5);
        repeat (2) add(1'b1, 4'hD, 1'b0, 4'hD, 1'b0, 1'b0, 4'h5);
        add(1'b1, 4'hF, 1'b0, 4'hD, 1'b1, 1'b0, 4'h5);
        add(1'b1, 4'hF, 1'b1, 4'hB, 1'b0, 1'b0, 4'h5);
        repeat (3) add(1'b1, 4'hE, 1'b0, 4'hB, 1'b0, 1'b0, 4'h5);
        add(1'b1, 4'hE, 1'b0, 4'hB, 1'b1, 1'b0, 4'h5);
        add(1'b1, 4'hF, 1'b1, 4'h7, 1'b0, 1'b0, 4'h5);

        use_stub = 1'b0;
        for (int i = 0; i < ntbl; i++) begin
            reset = tbl[i].rst; cols = tbl[i].cols; tb_done = tbl[i].done;
            step();
            check($sformatf("vec%0d_rows", i), rows, tbl[i].rows);
            check($sformatf("vec%0d_en", i), en, tbl[i].en);
            check($sformatf("vec%0d_kv", i), kv, tbl[i].kv);
            check($sformatf("vec%0d_kc", i), kc, tbl[i].kc);
        end
        tb_done = 1'b0;
        use_stub = 1'b1;

        // Press 5 and release after two enabled cycles: abort, scan moves on.
        do_reset();
        wait_rows(4'hD, "t4_reach_row1");
        cols = 4'hD;
        begin
            int n = 0;
            while (en !== 1'b1 && n < 20) begin step(); n++; end
        end
        check("t4_en_high", en, 1'b1);
        step(); step();
        cols = 4'hF;
        step();
        check("t4_en_drop", en, 1'b0);
        check("t4_rows_adv", rows, 4'hB);
        check("t4_no_pulse", kv_count, 0);

        // Held 5, release bounce inside release debounce, then clean release.
        do_reset();
        wait_rows(4'hD, "t5_reach_row1");
        cols = 4'hD;
        wait_kv("t5_pulse");
        check("t5_code", kc, 4'h5);
        repeat (5) step();
        check("t5_single_pulse", kv_count, 1);
        check("t5_rows_frozen", rows, 4'hD);
        check("t5_hold_en", en, 1'b0);
        cols = 4'hF;
        step();
        check("t5_rel_en", en, 1'b1);
        step();
        cols = 4'hD;
        step();
        check("t5_bounce_en", en, 1'b0);
        cols = 4'hF;
        begin
            int n = 0;
            while (rows === 4'hD && n < 20) begin step(); n++; end
        end
        check("t5_resume_row", rows, 4'hB);
        check("t5_no_second", kv_count, 1);
        check("t5_code_held", kc, 4'h5);

        // Multi-column press ignored, then key D.
        do_reset();
        cols = 4'b1100;
        repeat (40) step();
        check("t6_multi_no_en", en_seen, 1'b0);
        cols = 4'hF;
        wait_rows(4'h7, "t6_reach_row3");
        cols = 4'h7;
        wait_kv("t6_pulse");
        check("t6_code", kc, 4'hD);
        check("t6_one_pulse", kv_count, 1);

        // Reset lands while the release debounce is running.
        cols = 4'hF;
        step();
        check("t1_mid_en", en, 1'b1);
        reset = 1'b0;
        step();
        check("t1_rows", rows, 4'hE);
        check("t1_en", en, 1'b0);
        check("t1_kv", kv, 1'b0);
        check("t1_kc", kc, 4'h0);
        step();
        reset = 1'b1;

        // Randomized key activity against the model.
        reset = 1'b0;
        hold = 0;
        for (int c = 0; c < 3000; c++) begin
            if (hold == 0) begin
                sel = $urandom_range(0, 9);
                if (sel < 5) cols = 4'hF;
                else if (sel < 9) cols = ~(4'b0001 << $urandom_range(0, 3));
                else cols = 4'($urandom);
                hold = $urandom_range(1, 24);
            end
            hold--;
            if (c > 1) reset = ($urandom_range(0, 299) != 0);
            model_tick();
            exp_o = model_out();
            step();
            check("rand_outputs", {rows, en, kv, kc}, {21'd0, exp_o});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
